// File: rtl/multiplier.sv
// Combinational FP32 multiplier: 24x24 mantissa product, single normalise step,
// round-up on guard & sticky, with exception/overflow/underflow flags.
module multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);

  logic        sign;
  logic        norm;
  logic        round;
  logic        zero;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic [47:0] product;
  logic [46:0] prod_n;
  logic [22:0] mant;
  logic [8:0]  exponent;

  assign sign      = a[31] ^ b[31];
  assign exception = (&a[30:23]) | (&b[30:23]);
  assign mant_a    = {|a[30:23], a[22:0]};
  assign mant_b    = {|b[30:23], b[22:0]};
  assign product   = {24'd0, mant_a} * {24'd0, mant_b};
  assign norm      = product[47];
  assign prod_n    = norm ? product[46:0] : {product[45:0], 1'b0};
  assign round     = |prod_n[22:0];
  assign mant      = prod_n[46:24] + {22'd0, prod_n[23] & round};
  // An all-zero fraction after rounding is reported as a signed zero.
  assign zero      = ~exception & (mant == 23'd0);
  assign exponent  = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127 + {8'd0, norm};
  assign overflow  = exponent[8] & ~exponent[7] & ~zero;
  assign underflow = exponent[8] & exponent[7] & ~zero;

  always_comb begin
    if (exception) begin
      res = 32'd0;
    end else if (zero || underflow) begin
      res = {sign, 31'd0};
    end else if (overflow) begin
      res = {sign, 8'hff, 23'd0};
    end else begin
      res = {sign, exponent[7:0], mant};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier among NUM_REQ requesters.
// Granted operands run through a PIPE_STAGES-deep tagged pipeline; results return one-hot.
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_a,
  input  logic [NUM_REQ*32-1:0]      req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [31:0]                rsp_res,
  output logic                       rsp_exception,
  output logic                       rsp_overflow,
  output logic                       rsp_underflow,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] gidx;
  logic             gfound;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;

  always_comb begin
    logic [TAG_W-1:0] idx;
    idx       = '0;
    req_ready = '0;
    gidx      = '0;
    gfound    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = TAG_W'((32'(ptr) + k) % NUM_REQ);
      if (!gfound && !rst && req_valid[idx]) begin
        gfound         = 1'b1;
        req_ready[idx] = 1'b1;
        gidx           = idx;
      end
    end
  end

  // req_ready is one-hot or zero, so an OR-mux selects the granted operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a = sel_a | req_a[32*i +: 32];
        sel_b = sel_b | req_b[32*i +: 32];
      end
    end
  end

  assign grant_id = gidx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gfound) begin
      ptr <= (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    end
  end

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= gfound;
      if (gfound) begin
        s1_tag <= gidx;
        s1_a   <= sel_a;
        s1_b   <= sel_b;
      end
    end
  end

  logic [31:0] m_res;
  logic        m_exc;
  logic        m_ovf;
  logic        m_unf;

  multiplier u_mul (
    .a         (s1_a),
    .b         (s1_b),
    .res       (m_res),
    .exception (m_exc),
    .overflow  (m_ovf),
    .underflow (m_unf)
  );

  logic             last_valid;
  logic [TAG_W-1:0] last_tag;
  logic [31:0]      last_res;
  logic [2:0]       last_flags;
  logic             pipe_busy;

  if (PIPE_STAGES > 1) begin : gen_pipe
    localparam int unsigned NS = PIPE_STAGES - 1;

    logic [NS-1:0]    pv;
    logic [TAG_W-1:0] pt [NS];
    logic [31:0]      pr [NS];
    logic [2:0]       pf [NS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pv <= '0;
        for (int s = 0; s < NS; s++) begin
          pt[s] <= '0;
          pr[s] <= '0;
          pf[s] <= '0;
        end
      end else begin
        pv[0] <= s1_valid;
        pt[0] <= s1_tag;
        pr[0] <= m_res;
        pf[0] <= {m_exc, m_ovf, m_unf};
        for (int s = 1; s < NS; s++) begin
          pv[s] <= pv[s-1];
          pt[s] <= pt[s-1];
          pr[s] <= pr[s-1];
          pf[s] <= pf[s-1];
        end
      end
    end

    assign last_valid = pv[NS-1];
    assign last_tag   = pt[NS-1];
    assign last_res   = pr[NS-1];
    assign last_flags = pf[NS-1];
    assign pipe_busy  = |pv;
  end else begin : gen_comb
    assign last_valid = s1_valid;
    assign last_tag   = s1_tag;
    assign last_res   = m_res;
    assign last_flags = {m_exc, m_ovf, m_unf};
    assign pipe_busy  = 1'b0;
  end

  always_comb begin
    rsp_valid = '0;
    if (last_valid) begin
      rsp_valid[last_tag] = 1'b1;
    end
  end

  assign rsp_res                                       = last_res;
  assign {rsp_exception, rsp_overflow, rsp_underflow} = last_flags;
  assign busy                                          = s1_valid | pipe_busy;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios plus random traffic checked against a
// queue-based model of round-robin grants and FP32 products.
module tb_fp_mul_arbiter;

  localparam int N  = 4;
  localparam int P  = 2;
  localparam int TW = 2;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic        ovf;
    logic        unf;
  } prod_t;

  typedef struct {
    int    due;
    int    tag;
    prod_t p;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_res;
  logic            rsp_exception;
  logic            rsp_overflow;
  logic            rsp_underflow;
  logic            busy;
  logic [TW-1:0]   grant_id;

  int checks = 0;
  int errors = 0;

  int       model_ptr = 0;
  int       cyc = 0;
  rsp_t     pend[$];
  logic [N-1:0] exp_ready;
  logic [N-1:0] exp_rsp;
  int       exp_gid;
  prod_t    exp_p;
  logic     exp_busy;

  always #5 clk = ~clk;

  fp_mul_arbiter #(
    .NUM_REQ     (N),
    .PIPE_STAGES (P)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_res       (rsp_res),
    .rsp_exception (rsp_exception),
    .rsp_overflow  (rsp_overflow),
    .rsp_underflow (rsp_underflow),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  // Reference product from the arithmetic rules: hidden bit, one normalise step,
  // round up when guard and any lower bit are set, 9-bit biased exponent wrap.
  function automatic prod_t ref_mul(input logic [31:0] a, input logic [31:0] b);
    prod_t           r;
    longint unsigned ma, mb, p, mant;
    int              ea, eb, e, em;
    bit              norm, zero, sign, guard, sticky;
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    sign   = a[31] ^ b[31];
    r.exc  = (ea == 255) || (eb == 255);
    ma     = ((ea != 0) ? 64'h80_0000 : 64'h0) + 64'(a[22:0]);
    mb     = ((eb != 0) ? 64'h80_0000 : 64'h0) + 64'(b[22:0]);
    p      = ma * mb;
    norm   = p >= 64'h8000_0000_0000;
    if (!norm) p = p * 2;
    guard  = ((p >> 23) % 2) == 1;
    sticky = (p % 64'h80_0000) != 0;
    mant   = ((p >> 24) + ((guard && sticky) ? 1 : 0)) % 64'h80_0000;
    zero   = !r.exc && (mant == 0);
    e      = ea + eb - 127 + (norm ? 1 : 0);
    em     = (e + 512) % 512;
    r.ovf  = !zero && em >= 256 && em < 384;
    r.unf  = !zero && em >= 384;
    if (r.exc)                r.res = 32'd0;
    else if (zero || r.unf)   r.res = {sign, 31'd0};
    else if (r.ovf)           r.res = {sign, 8'hff, 23'd0};
    else                      r.res = {sign, 8'(em), 23'(mant)};
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h7f80_0000;
      1:       v = 32'h0000_0000;
      2, 3, 4: v = $urandom;
      default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
    return v;
  endfunction

  task automatic model_eval();
    exp_ready = '0;
    exp_gid   = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (model_ptr + k) % N;
      if (exp_ready == '0 && req_valid[idx]) begin
        exp_ready[idx] = 1'b1;
        exp_gid        = idx;
      end
    end
    exp_rsp = '0;
    exp_p   = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rsp[pend[0].tag] = 1'b1;
      exp_p                = pend[0].p;
    end
    exp_busy = pend.size() > 0;
  endtask

  task automatic model_commit();
    rsp_t r;
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    if (exp_ready != '0) begin
      r.due = cyc + P;
      r.tag = exp_gid;
      r.p   = ref_mul(req_a[32*exp_gid +: 32], req_b[32*exp_gid +: 32]);
      pend.push_back(r);
      model_ptr = (exp_gid + 1) % N;
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    pend.delete();
    model_ptr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, grant_id, rsp_valid, rsp_res, rsp_exception, rsp_overflow, rsp_underflow,
         busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b gid=%0d rsp=%b res=%h busy=%b, want all 0",
               req_ready, grant_id, rsp_valid, rsp_res, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    model_ptr = 0;
    sample();
    checks++;
    if ({req_ready, grant_id, rsp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got ready=%b gid=%0d rsp=%b busy=%b, want 0",
               req_ready, grant_id, rsp_valid, busy);
    end
    advance();
  endtask

  task automatic test_single();
    req_a[64 +: 32] = 32'h4000_0000;
    req_b[64 +: 32] = 32'h4040_0000;
    req_valid       = 4'b0100;
    sample();
    checks++;
    if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_grant: got ready=%b gid=%0d, want 0100 gid=2", req_ready, grant_id);
    end
    advance();
    req_valid = '0;
    sample();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_inflight: got rsp=%b busy=%b, want 0000 busy=1", rsp_valid, busy);
    end
    advance();
    sample();
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_res !== 32'h40c0_0000 ||
        {rsp_exception, rsp_overflow, rsp_underflow} !== 3'b000) begin
      errors++;
      $display("FAIL single_rsp: got rsp=%b res=%h flags=%b, want 0100 40c00000 000",
               rsp_valid, rsp_res, {rsp_exception, rsp_overflow, rsp_underflow});
    end
    checks++;
    if ({rsp_res, rsp_exception, rsp_overflow, rsp_underflow} !== exp_p) begin
      errors++;
      $display("FAIL single_model: got %h want %h",
               {rsp_res, rsp_exception, rsp_overflow, rsp_underflow}, exp_p);
    end
    advance();
    sample();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got rsp=%b busy=%b, want 0000 busy=0", rsp_valid, busy);
    end
    advance();
  endtask

  task automatic test_contention();
    logic [N-1:0] oh;
    int           dut_seen;
    dut_seen = 0;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h3fc0_0000;
      req_b[32*i +: 32] = 32'h3fc0_0000;
    end
    req_valid = '1;
    for (int k = 0; k < 12 + P + 2; k++) begin
      if (k == 12) req_valid = '0;
      sample();
      if (k < 12) begin
        oh         = '0;
        oh[k % N]  = 1'b1;
        checks++;
        if (req_ready !== oh || grant_id !== 2'(k % N)) begin
          errors++;
          $display("FAIL contention_grant %0d: got ready=%b gid=%0d, want %b", k, req_ready,
                   grant_id, oh);
        end
      end
      checks++;
      if (rsp_valid !== exp_rsp || busy !== exp_busy) begin
        errors++;
        $display("FAIL contention_rsp %0d: got rsp=%b busy=%b, want %b busy=%b", k, rsp_valid,
                 busy, exp_rsp, exp_busy);
      end
      if (exp_rsp != '0) begin
        checks++;
        if (rsp_res !== 32'h4010_0000 || {rsp_exception, rsp_overflow, rsp_underflow} !== 3'b0)
        begin
          errors++;
          $display("FAIL contention_res %0d: got %h want 40100000", k, rsp_res);
        end
      end
      if (rsp_valid != '0) dut_seen++;
      advance();
    end
    checks++;
    if (dut_seen != 12) begin
      errors++;
      $display("FAIL contention_count: got %0d responses, want 12", dut_seen);
    end
  endtask

  task automatic test_flags();
    req_a[32 +: 32] = 32'h7f80_0000;
    req_b[32 +: 32] = 32'h4000_0000;
    req_a[96 +: 32] = 32'h7f40_0000;
    req_b[96 +: 32] = 32'h7f40_0000;
    for (int k = 0; k < P + 4; k++) begin
      req_valid = (k == 0) ? 4'b0010 : (k == 1) ? 4'b1000 : 4'b0000;
      sample();
      checks++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp ||
          (exp_rsp != '0 && {rsp_res, rsp_exception, rsp_overflow, rsp_underflow} !== exp_p))
      begin
        errors++;
        $display("FAIL flags_model %0d: got ready=%b rsp=%b res=%h, want %b %b %h", k, req_ready,
                 rsp_valid, rsp_res, exp_ready, exp_rsp, exp_p.res);
      end
      if (exp_rsp == 4'b0010) begin
        checks++;
        if (rsp_res !== 32'h0 || rsp_exception !== 1'b1) begin
          errors++;
          $display("FAIL flags_exception: got res=%h exc=%b, want 0 exc=1", rsp_res,
                   rsp_exception);
        end
      end
      if (exp_rsp == 4'b1000) begin
        checks++;
        if (rsp_res !== 32'h7f80_0000 || rsp_overflow !== 1'b1 || rsp_exception !== 1'b0) begin
          errors++;
          $display("FAIL flags_overflow: got res=%h ovf=%b exc=%b, want 7f800000 1 0", rsp_res,
                   rsp_overflow, rsp_exception);
        end
      end
      advance();
    end
  endtask

  task automatic test_fairness();
    int           waitc [N];
    int           max_wait;
    logic [N-1:0] granted;
    max_wait = 0;
    apply_reset();
    req_a[0 +: 32]  = pick();
    req_b[0 +: 32]  = pick();
    req_a[64 +: 32] = pick();
    req_b[64 +: 32] = pick();
    req_valid = 4'b0001;
    sample();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL gap_first: got %b want 0001", req_ready);
    end
    advance();
    req_valid = 4'b0101;
    sample();
    checks++;
    if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL gap_req2: got ready=%b gid=%0d, want 0100 gid=2", req_ready, grant_id);
    end
    advance();
    req_valid = 4'b0001;
    sample();
    checks++;
    if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL gap_req0: got ready=%b gid=%0d, want 0001 gid=0", req_ready, grant_id);
    end
    advance();
    req_valid = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 1000 + P + 2; c++) begin
      if (c < 1000) begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            req_valid[i]      = 1'b1;
            req_a[32*i +: 32] = pick();
            req_b[32*i +: 32] = pick();
          end
        end
      end else begin
        req_valid = '0;
      end
      sample();
      checks++;
      if (req_ready !== exp_ready || grant_id !== 2'(exp_gid)) begin
        errors++;
        $display("FAIL rand_grant %0d: got ready=%b gid=%0d, want %b gid=%0d", c, req_ready,
                 grant_id, exp_ready, exp_gid);
      end
      checks++;
      if (rsp_valid !== exp_rsp || busy !== exp_busy ||
          (exp_rsp != '0 && {rsp_res, rsp_exception, rsp_overflow, rsp_underflow} !== exp_p))
      begin
        errors++;
        $display("FAIL rand_rsp %0d: got rsp=%b busy=%b out=%h, want %b busy=%b out=%h", c,
                 rsp_valid, busy, {rsp_res, rsp_exception, rsp_overflow, rsp_underflow},
                 exp_rsp, exp_busy, exp_p);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          waitc[i]++;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end else begin
          waitc[i] = 0;
        end
      end
      granted = req_ready;
      advance();
      req_valid = req_valid & ~granted;
    end
    checks++;
    if (max_wait > N - 1) begin
      errors++;
      $display("FAIL fairness_max_wait: got %0d cycles, want <= %0d", max_wait, N - 1);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req_a[0 +: 32] = 32'h3fc0_0000;
    req_b[0 +: 32] = 32'h3fc0_0000;
    req_valid      = 4'b0001;
    sample();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midflight_grant: got %b want 0001", req_ready);
    end
    advance();
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midflight_busy_before: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL midflight_busy_after: got busy=%b rsp=%b, want 0 0000", busy, rsp_valid);
    end
    pend.delete();
    model_ptr = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) rst = 1'b0;
      sample();
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midflight_discard %0d: got rsp=%b busy=%b, want 0000 0", k, rsp_valid,
                 busy);
      end
      advance();
    end
    req_a[32 +: 32] = 32'h4000_0000;
    req_b[32 +: 32] = 32'h3f80_0000;
    req_valid       = 4'b0011;
    sample();
    checks++;
    if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL midflight_ptr: got ready=%b gid=%0d, want 0001 gid=0", req_ready, grant_id);
    end
    advance();
    req_valid = 4'b0010;
    sample();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL midflight_second: got %b want 0010", req_ready);
    end
    advance();
    req_valid = '0;
    for (int k = 0; k < P + 1; k++) begin
      sample();
      checks++;
      if (rsp_valid !== exp_rsp ||
          (exp_rsp != '0 && {rsp_res, rsp_exception, rsp_overflow, rsp_underflow} !== exp_p))
      begin
        errors++;
        $display("FAIL midflight_rsp %0d: got rsp=%b res=%h, want %b %h", k, rsp_valid, rsp_res,
                 exp_rsp, exp_p.res);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    int run;
    int max_run;
    run     = 0;
    max_run = 0;
    apply_reset();
    for (int k = 0; k < 3 + P + 2; k++) begin
      if (k < 3) begin
        req_valid      = 4'b0001;
        req_a[0 +: 32] = pick();
        req_b[0 +: 32] = pick();
      end else begin
        req_valid = '0;
      end
      sample();
      if (k < 3) begin
        checks++;
        if (req_ready !== 4'b0001) begin
          errors++;
          $display("FAIL b2b_grant %0d: got %b want 0001", k, req_ready);
        end
      end
      checks++;
      if (rsp_valid !== exp_rsp || busy !== exp_busy ||
          (exp_rsp != '0 && {rsp_res, rsp_exception, rsp_overflow, rsp_underflow} !== exp_p))
      begin
        errors++;
        $display("FAIL b2b_rsp %0d: got rsp=%b busy=%b res=%h, want %b busy=%b res=%h", k,
                 rsp_valid, busy, rsp_res, exp_rsp, exp_busy, exp_p.res);
      end
      if (rsp_valid[0] === 1'b1) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      advance();
    end
    checks++;
    if (max_run != 3) begin
      errors++;
      $display("FAIL b2b_consecutive: got %0d consecutive responses, want 3", max_run);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_flags();
    test_fairness();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
